qmeas_responder: RTL and testbench

- Plant-side counterpart of the secant current-reference controller.
- Accepts the controller's i_ref code and drives it to the DAC.
- Waits a settling interval, then takes a power-of-2 number of ADC conversions and averages them.
- Returns the averaged result as q_measured and pulses ready, which advances the controller's iteration.

---
 rtl/qmeas_pkg.sv | 26 ++
 rtl/qmeas_avg_acc.sv | 55 +++++
 rtl/qmeas_responder.sv | 201 ++++++++++++++++++++
 tb/tb_qmeas_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/qmeas_pkg.sv
`default_nettype none
// ============================================================================
// qmeas_pkg : shared state encoding and constants for qmeas_responder
// Rev 1.0
// ============================================================================
package qmeas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } qmeas_state_e;

   localparam int unsigned SAT_MAX_WIDTH = 32;
   localparam logic [SAT_MAX_WIDTH-1:0] SAT_ALL_ONES = '1;

   // Sum of 2**log2_avg unsigned bus_width-bit samples never exceeds this width
   function automatic int unsigned acc_width(input int unsigned bus_width,
                                             input int unsigned log2_avg);
      return bus_width + log2_avg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/qmeas_avg_acc.sv
`default_nettype none
// ============================================================================
// qmeas_avg_acc : sample accumulator and counter producing a truncated mean
// Rev 1.0
// ============================================================================
module qmeas_avg_acc
   import qmeas_pkg::*;
#(
   parameter int unsigned BUS_WIDTH = 10,
   parameter int unsigned LOG2_AVG  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 add,
   input  logic [BUS_WIDTH-1:0] data,
   output logic                 full,
   output logic [BUS_WIDTH-1:0] mean
);

   localparam int unsigned      ACC_W    = acc_width(BUS_WIDTH, LOG2_AVG);
   localparam int unsigned      CNT_W    = LOG2_AVG + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (add) begin
         acc_d = acc_q + ACC_W'(data);
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Flags the add that completes the set so the caller can branch in that cycle
   assign full = add && !clear && (cnt_q == CNT_LAST);
   assign mean = acc_q[ACC_W-1:LOG2_AVG];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/qmeas_responder.sv
`default_nettype none
// ============================================================================
// qmeas_responder : drives i_ref to the DAC, settles, averages ADC samples and
// returns q_measured with a ready pulse. Optional watchdog: QMEAS_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module qmeas_responder
   import qmeas_pkg::*;
#(
   parameter int unsigned BUS_WIDTH     = 10,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned LOG2_AVG      = 2,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic                 meas_req,
   input  logic [BUS_WIDTH-1:0] adc_data,
   input  logic                 adc_valid,
   output logic [BUS_WIDTH-1:0] dac_code,
   output logic                 adc_start,
   output logic [BUS_WIDTH-1:0] q_measured,
   output logic                 ready,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int unsigned      SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || LOG2_AVG > 4 || TIMEOUT < 1) begin : g_param_check
      $fatal(1, "qmeas_responder: illegal parameter set");
   end

   qmeas_state_e         state_q, state_d;
   logic [BUS_WIDTH-1:0] dac_code_q, dac_code_d;
   logic [BUS_WIDTH-1:0] last_ref_q, last_ref_d;
   logic [BUS_WIDTH-1:0] q_meas_q, q_meas_d;
   logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
   logic                 ready_q, ready_d;
   logic                 adc_start_q, adc_start_d;
   logic                 busy_q, busy_d;

   logic                 ref_changed;
   logic                 launch;
   logic                 acc_clear;
   logic                 acc_add;
   logic                 acc_full;
   logic [BUS_WIDTH-1:0] acc_mean;

`ifdef QMEAS_TIMEOUT_EN
   localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_err_q, timeout_err_d;
`endif

   assign ref_changed = (i_ref != last_ref_q);

   qmeas_avg_acc #(
      .BUS_WIDTH (BUS_WIDTH),
      .LOG2_AVG  (LOG2_AVG)
   ) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clear (acc_clear),
      .add   (acc_add),
      .data  (adc_data),
      .full  (acc_full),
      .mean  (acc_mean)
   );

   always_comb begin
      state_d      = state_q;
      dac_code_d   = dac_code_q;
      last_ref_d   = last_ref_q;
      q_meas_d     = q_meas_q;
      settle_cnt_d = settle_cnt_q;
      ready_d      = 1'b0;
      adc_start_d  = 1'b0;
      acc_clear    = 1'b0;
      acc_add      = 1'b0;
      launch       = 1'b0;
`ifdef QMEAS_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            launch = ref_changed || meas_req;
         end
         ST_SETTLE: begin
            if (ref_changed) begin
               launch = 1'b1;
            end else if (settle_cnt_q == SET_LAST) begin
               state_d     = ST_START;
               adc_start_d = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
         end
         ST_START: begin
            if (ref_changed) begin
               launch = 1'b1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A reference change outranks a sample arriving in the same cycle
            if (ref_changed) begin
               launch = 1'b1;
            end else if (adc_valid) begin
               acc_add = 1'b1;
               if (acc_full) begin
                  state_d = ST_DONE;
               end else begin
                  state_d     = ST_START;
                  adc_start_d = 1'b1;
               end
            end
`ifdef QMEAS_TIMEOUT_EN
            else if (wd_cnt_q == WD_LAST) begin
               timeout_err_d = 1'b1;
               q_meas_d      = SAT_ALL_ONES[BUS_WIDTH-1:0];
               ready_d       = 1'b1;
               state_d       = ST_IDLE;
            end
`endif
         end
         ST_DONE: begin
            q_meas_d = acc_mean;
            ready_d  = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (launch) begin
         dac_code_d   = i_ref;
         last_ref_d   = i_ref;
         acc_clear    = 1'b1;
         settle_cnt_d = '0;
         adc_start_d  = 1'b0;
         state_d      = ST_SETTLE;
      end

      busy_d = (state_d != ST_IDLE);

`ifdef QMEAS_TIMEOUT_EN
      wd_cnt_d = (state_q == ST_WAIT && state_d == ST_WAIT) ? wd_cnt_q + WD_W'(1) : '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         dac_code_q   <= '0;
         last_ref_q   <= '0;
         q_meas_q     <= '0;
         settle_cnt_q <= '0;
         ready_q      <= 1'b0;
         adc_start_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef QMEAS_TIMEOUT_EN
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         dac_code_q   <= dac_code_d;
         last_ref_q   <= last_ref_d;
         q_meas_q     <= q_meas_d;
         settle_cnt_q <= settle_cnt_d;
         ready_q      <= ready_d;
         adc_start_q  <= adc_start_d;
         busy_q       <= busy_d;
`ifdef QMEAS_TIMEOUT_EN
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign dac_code   = dac_code_q;
   assign adc_start  = adc_start_q;
   assign q_measured = q_meas_q;
   assign ready      = ready_q;
   assign busy       = busy_q;
`ifdef QMEAS_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qmeas_responder.sv
`default_nettype none
// ============================================================================
// tb_qmeas_responder : directed/randomized bench with an ADC responder and a
// latency/mean reference computed from settle, sample count and ADC wait.
// ============================================================================
module tb_qmeas_responder;

   localparam int BW = 10;
   localparam int S  = 4;
   localparam int L  = 2;
   localparam int N  = 1 << L;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] i_ref;
   logic          meas_req;
   logic [BW-1:0] adc_data;
   logic          adc_valid;
   logic [BW-1:0] dac_code;
   logic          adc_start;
   logic [BW-1:0] q_measured;
   logic          ready;
   logic          busy;
   logic          timeout_err;

   int total = 0;
   int bad   = 0;
   int ready_cnt = 0;

   always #5 clk = ~clk;

   qmeas_responder #(
      .BUS_WIDTH     (BW),
      .SETTLE_CYCLES (S),
      .LOG2_AVG      (L)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_ref       (i_ref),
      .meas_req    (meas_req),
      .adc_data    (adc_data),
      .adc_valid   (adc_valid),
      .dac_code    (dac_code),
      .adc_start   (adc_start),
      .q_measured  (q_measured),
      .ready       (ready),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (ready === 1'b1) ready_cnt++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dac"},   32'(dac_code),   0);
      check({tag, "_q"},     32'(q_measured), 0);
      check({tag, "_ready"}, 32'(ready),      0);
      check({tag, "_start"}, 32'(adc_start),  0);
      check({tag, "_busy"},  32'(busy),       0);
      check({tag, "_terr"},  32'(timeout_err), 0);
   endtask

   // One measurement: trigger, answer every adc_start after adc_wait extra
   // cycles, optionally abort on the abort_nth start, then check the result.
   task automatic measure(input string tag, input bit use_req, input logic [BW-1:0] ref_val,
                          input int base, input int stepv, input int adc_wait,
                          input int abort_nth, input logic [BW-1:0] abort_ref,
                          input bit stray, input bit req_busy);
      int cyc, nstart, countdown, k, sum, lat, r0, abort_left;
      bit got, abort_next;
      logic [BW-1:0] d, exp_ref;
      r0 = ready_cnt;
      exp_ref = ref_val;
      i_ref = ref_val;
      meas_req = use_req;
      cyc = 0; nstart = 0; countdown = 0; k = 0; sum = 0; lat = 0;
      got = 1'b0; abort_next = 1'b0; abort_left = abort_nth;
      while (!got && cyc < 400) begin
         tick();
         cyc++;
         meas_req  = 1'b0;
         adc_valid = 1'b0;
         adc_data  = '0;
         if (ready === 1'b1) begin
            got = 1'b1;
            lat = cyc;
         end
         if (abort_next) begin
            i_ref = abort_ref;
            exp_ref = abort_ref;
            adc_valid = 1'b1;
            adc_data = '1;
            countdown = 0; sum = 0; k = 0; nstart = 0; cyc = 0;
            abort_next = 1'b0;
         end else begin
            if (cyc == 1) check({tag, "_busy_active"}, 32'(busy), 1);
            if (req_busy && cyc == 3) meas_req = 1'b1;
            if (stray && cyc >= 1 && cyc <= 3) begin
               adc_valid = 1'b1;
               adc_data  = '1;
            end
            if (countdown > 0) begin
               countdown--;
               if (countdown == 0) begin
                  if (base < 0) d = BW'($urandom_range(0, 1023));
                  else          d = BW'(base + stepv * k);
                  adc_valid = 1'b1;
                  adc_data  = d;
                  sum += int'(d);
                  k++;
               end
            end
            if (adc_start === 1'b1) begin
               nstart++;
               countdown = adc_wait + 1;
               if (abort_left > 0 && nstart == abort_left) begin
                  abort_next = 1'b1;
                  abort_left = 0;
               end
            end
         end
      end
      check({tag, "_ready_seen"}, 32'(got), 1);
      check({tag, "_latency"}, 32'(lat), 32'(2 + S + N * (2 + adc_wait)));
      check({tag, "_mean"}, 32'(q_measured), 32'(sum / N));
      check({tag, "_starts"}, 32'(nstart), 32'(N));
      check({tag, "_dac"}, 32'(dac_code), 32'(exp_ref));
      check({tag, "_busy_end"}, 32'(busy), 0);
      repeat (20) tick();
      check({tag, "_ready_once"}, 32'(ready_cnt - r0), 1);
      check({tag, "_mean_held"}, 32'(q_measured), 32'(sum / N));
   endtask

   initial begin
      logic [BW-1:0] r;
      logic [BW-1:0] q_hold;
      int r0;
      rst = 1'b1; i_ref = '0; meas_req = 1'b0; adc_data = '0; adc_valid = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 0);

      measure("basic",  1'b0, 10'd512, 100, 2, 0, 0, '0, 1'b0, 1'b0);
      measure("remeas", 1'b1, 10'd512, 200, 0, 0, 0, '0, 1'b0, 1'b1);
      measure("abort",  1'b1, 10'd512, -1,  0, 0, 2, 10'd700, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         do r = BW'($urandom_range(0, 1023)); while (r == i_ref);
         measure("rand", 1'b0, r, -1, 0, int'($urandom_range(0, 3)), 0, '0, 1'b0, 1'b0);
      end

      q_hold = q_measured;
      repeat (3) begin
         tick();
         adc_valid = 1'b1;
         adc_data  = '1;
      end
      tick();
      adc_valid = 1'b0;
      tick();
      check("stray_idle_busy", 32'(busy), 0);
      check("stray_idle_q", 32'(q_measured), 32'(q_hold));
      measure("stray", 1'b1, i_ref, -1, 0, 0, 0, '0, 1'b1, 1'b0);

      do r = BW'($urandom_range(1, 1023)); while (r == i_ref);
      i_ref = r;
      tick();
      tick();
      check("midrst_busy_before", 32'(busy), 1);
      rst = 1'b1;
      i_ref = '0;
      r0 = ready_cnt;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      repeat (4) begin
         tick();
         adc_valid = 1'b1;
         adc_data  = '1;
      end
      tick();
      adc_valid = 1'b0;
      repeat (20) tick();
      check("midrst_busy_after", 32'(busy), 0);
      check("midrst_q_after", 32'(q_measured), 0);
      check("midrst_no_ready", 32'(ready_cnt - r0), 0);

      r = BW'($urandom_range(1, 1023));
      measure("post_rst", 1'b0, r, -1, 0, 1, 0, '0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
